// File: rtl/collision_scheduler.sv
// rtl/collision_scheduler.sv - per-frame T-rex vs obstacle collision checker sharing one box comparator
module collision_scheduler #(
    parameter int MAX_OBSTACLES = 3,
    parameter int IDX_W         = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     clear,
    input  logic signed [11:0]       trex_x,
    input  logic signed [11:0]       trex_y,
    input  logic [9:0]               trex_w,
    input  logic [9:0]               trex_h,
    input  logic                     trex_duck,
    input  logic [MAX_OBSTACLES-1:0] obs_valid,
    input  logic signed [10:0]       obs_x    [MAX_OBSTACLES],
    input  logic [9:0]               obs_y    [MAX_OBSTACLES],
    input  logic [9:0]               obs_w    [MAX_OBSTACLES],
    input  logic [9:0]               obs_h    [MAX_OBSTACLES],
    input  logic [1:0]               obs_size [MAX_OBSTACLES],
    input  logic [1:0]               obs_kind [MAX_OBSTACLES],
    output logic                     busy,
    output logic                     done,
    output logic                     hit,
    output logic [IDX_W-1:0]         hit_index
);

    typedef enum logic [1:0] {IDLE, COARSE, FINE, FINISH} state_t;

    typedef struct packed {
        logic signed [13:0] x;
        logic signed [13:0] y;
        logic signed [13:0] w;
        logic signed [13:0] h;
    } box_t;

    function automatic box_t mk(input int x, input int y, input int w, input int h);
        mk.x = 14'(x);
        mk.y = 14'(y);
        mk.w = 14'(w);
        mk.h = 14'(h);
    endfunction

    // Strict overlap; degenerate boxes never collide.
    function automatic logic overlap(input box_t a, input box_t b);
        return (a.w > 0) && (a.h > 0) && (b.w > 0) && (b.h > 0) &&
               (a.x < b.x + b.w) && (b.x < a.x + a.w) &&
               (a.y < b.y + b.h) && (b.y < a.y + a.h);
    endfunction

    state_t state, state_next;

    logic signed [11:0]       s_tx, s_ty;
    logic [9:0]               s_tw, s_th;
    logic                     s_duck;
    logic [MAX_OBSTACLES-1:0] s_valid;
    logic signed [10:0]       s_ox   [MAX_OBSTACLES];
    logic [9:0]               s_oy   [MAX_OBSTACLES];
    logic [9:0]               s_ow   [MAX_OBSTACLES];
    logic [9:0]               s_oh   [MAX_OBSTACLES];
    logic [1:0]               s_size [MAX_OBSTACLES];
    logic [1:0]               s_kind [MAX_OBSTACLES];

    logic [IDX_W-1:0] i;
    logic [2:0]       t, o;

    logic signed [10:0] sel_ox;
    logic [9:0]         sel_oy, sel_ow, sel_oh;
    logic [1:0]         sel_size, sel_kind;
    logic               sel_valid;

    logic signed [13:0] tx, ty, tw, th, ox, oy, ow, oh, osz, ow_tot;
    logic signed [13:0] edge_w0, edge_w2;
    box_t tbox, obox, cmp_a, cmp_b;
    logic ovl, slot_skip, slot_last, o_last_hit, t_last_hit;
    logic [2:0] t_last, o_last;

    assign sel_ox    = s_ox[i];
    assign sel_oy    = s_oy[i];
    assign sel_ow    = s_ow[i];
    assign sel_oh    = s_oh[i];
    assign sel_size  = s_size[i];
    assign sel_kind  = s_kind[i];
    assign sel_valid = s_valid[i];

    assign tx     = {{2{s_tx[11]}}, s_tx};
    assign ty     = {{2{s_ty[11]}}, s_ty};
    assign tw     = {4'd0, s_tw};
    assign th     = {4'd0, s_th};
    assign ox     = {{3{sel_ox[10]}}, sel_ox};
    assign oy     = {4'd0, sel_oy};
    assign ow     = {4'd0, sel_ow};
    assign oh     = {4'd0, sel_oh};
    assign osz    = {12'd0, sel_size};
    assign ow_tot = ow * osz;

    assign edge_w0 = sel_kind[0] ? 14'sd7  : 14'sd5;
    assign edge_w2 = sel_kind[0] ? 14'sd10 : 14'sd7;

    always_comb begin
        tbox = mk(0, 0, 0, 0);
        if (s_duck) begin
            tbox = mk(1, 18, 55, 25);
        end else begin
            case (t)
                3'd0:    tbox = mk(22, 0, 17, 16);
                3'd1:    tbox = mk(1, 18, 30, 9);
                3'd2:    tbox = mk(10, 35, 14, 8);
                3'd3:    tbox = mk(1, 24, 29, 5);
                3'd4:    tbox = mk(5, 30, 21, 4);
                3'd5:    tbox = mk(9, 34, 15, 4);
                default: tbox = mk(0, 0, 0, 0);
            endcase
        end
    end

    always_comb begin
        obox = mk(0, 0, 0, 0);
        case (sel_kind)
            2'd0: case (o)
                3'd0:    obox = mk(0, 7, 5, 27);
                3'd1:    obox = mk(4, 0, 6, 34);
                3'd2:    obox = mk(10, 4, 7, 14);
                default: obox = mk(0, 0, 0, 0);
            endcase
            2'd1: case (o)
                3'd0:    obox = mk(0, 12, 7, 38);
                3'd1:    obox = mk(8, 0, 7, 49);
                3'd2:    obox = mk(13, 10, 10, 38);
                default: obox = mk(0, 0, 0, 0);
            endcase
            2'd2: case (o)
                3'd0:    obox = mk(15, 15, 16, 5);
                3'd1:    obox = mk(18, 21, 24, 6);
                3'd2:    obox = mk(2, 14, 4, 3);
                3'd3:    obox = mk(6, 10, 4, 7);
                3'd4:    obox = mk(10, 8, 6, 9);
                default: obox = mk(0, 0, 0, 0);
            endcase
            default: obox = mk(0, 0, 0, 0);
        endcase
        // Grouped cacti stretch the middle box and push the right box to the far edge.
        if (!sel_kind[1] && sel_size > 2'd1) begin
            if (o == 3'd1) obox.w = ow_tot - edge_w0 - edge_w2;
            if (o == 3'd2) obox.x = ow_tot - edge_w2;
        end
    end

    always_comb begin
        cmp_a = mk(0, 0, 0, 0);
        cmp_b = mk(0, 0, 0, 0);
        if (state == FINE) begin
            cmp_a.x = tx + tbox.x;
            cmp_a.y = ty + tbox.y;
            cmp_a.w = tbox.w;
            cmp_a.h = tbox.h;
            cmp_b.x = ox + obox.x;
            cmp_b.y = oy + obox.y;
            cmp_b.w = obox.w;
            cmp_b.h = obox.h;
        end else begin
            cmp_a.x = tx + 14'sd1;
            cmp_a.y = ty + 14'sd1;
            cmp_a.w = tw - 14'sd2;
            cmp_a.h = th - 14'sd2;
            cmp_b.x = ox + 14'sd1;
            cmp_b.y = oy + 14'sd1;
            cmp_b.w = ow_tot - 14'sd2;
            cmp_b.h = oh - 14'sd2;
        end
    end

    assign ovl        = overlap(cmp_a, cmp_b);
    assign slot_skip  = !sel_valid || (sel_kind == 2'd3);
    assign slot_last  = (i == IDX_W'(MAX_OBSTACLES - 1));
    assign t_last     = s_duck ? 3'd0 : 3'd5;
    assign o_last     = (sel_kind == 2'd2) ? 3'd4 : 3'd2;
    assign t_last_hit = (t == t_last);
    assign o_last_hit = (o == o_last);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:   if (start) state_next = COARSE;
            COARSE: begin
                if (!slot_skip && ovl) state_next = FINE;
                else if (slot_last)    state_next = FINISH;
            end
            FINE: begin
                if (ovl)                            state_next = FINISH;
                else if (t_last_hit && o_last_hit)  state_next = slot_last ? FINISH : COARSE;
            end
            FINISH: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit       <= 1'b0;
            hit_index <= '0;
            i         <= '0;
            t         <= '0;
            o         <= '0;
            s_tx      <= '0;
            s_ty      <= '0;
            s_tw      <= '0;
            s_th      <= '0;
            s_duck    <= 1'b0;
            s_valid   <= '0;
            for (int k = 0; k < MAX_OBSTACLES; k++) begin
                s_ox[k]   <= '0;
                s_oy[k]   <= '0;
                s_ow[k]   <= '0;
                s_oh[k]   <= '0;
                s_size[k] <= '0;
                s_kind[k] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (clear) begin
                        hit       <= 1'b0;
                        hit_index <= '0;
                    end
                    if (start) begin
                        i       <= '0;
                        t       <= '0;
                        o       <= '0;
                        s_tx    <= trex_x;
                        s_ty    <= trex_y;
                        s_tw    <= trex_w;
                        s_th    <= trex_h;
                        s_duck  <= trex_duck;
                        s_valid <= obs_valid;
                        for (int k = 0; k < MAX_OBSTACLES; k++) begin
                            s_ox[k]   <= obs_x[k];
                            s_oy[k]   <= obs_y[k];
                            s_ow[k]   <= obs_w[k];
                            s_oh[k]   <= obs_h[k];
                            s_size[k] <= obs_size[k];
                            s_kind[k] <= obs_kind[k];
                        end
                    end
                end
                COARSE: begin
                    if (!slot_skip && ovl) begin
                        t <= '0;
                        o <= '0;
                    end else if (!slot_last) begin
                        i <= i + 1'b1;
                    end
                end
                FINE: begin
                    if (ovl) begin
                        hit       <= 1'b1;
                        hit_index <= i;
                    end else if (o_last_hit) begin
                        o <= '0;
                        if (!t_last_hit)     t <= t + 3'd1;
                        else if (!slot_last) i <= i + 1'b1;
                    end else begin
                        o <= o + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == COARSE) || (state == FINE);
    assign done = (state == FINISH);

endmodule

// File: tb/tb_collision_scheduler.sv
// tb/tb_collision_scheduler.sv - directed self-checking bench for collision_scheduler
module tb_collision_scheduler;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               clear;
    logic signed [11:0] trex_x, trex_y;
    logic [9:0]         trex_w, trex_h;
    logic               trex_duck;
    logic [2:0]         obs_valid;
    logic signed [10:0] obs_x    [3];
    logic [9:0]         obs_y    [3];
    logic [9:0]         obs_w    [3];
    logic [9:0]         obs_h    [3];
    logic [1:0]         obs_size [3];
    logic [1:0]         obs_kind [3];
    logic               busy, done, hit;
    logic [1:0]         hit_index;

    int vectors     = 0;
    int miscompares = 0;

    collision_scheduler #(.MAX_OBSTACLES(3), .IDX_W(2)) dut (
        .clk(clk), .rst(rst), .start(start), .clear(clear),
        .trex_x(trex_x), .trex_y(trex_y), .trex_w(trex_w), .trex_h(trex_h),
        .trex_duck(trex_duck), .obs_valid(obs_valid), .obs_x(obs_x), .obs_y(obs_y),
        .obs_w(obs_w), .obs_h(obs_h), .obs_size(obs_size), .obs_kind(obs_kind),
        .busy(busy), .done(done), .hit(hit), .hit_index(hit_index)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_trex(input int x, input int y, input int w, input int h, input logic duck);
        trex_x    = 12'(x);
        trex_y    = 12'(y);
        trex_w    = 10'(w);
        trex_h    = 10'(h);
        trex_duck = duck;
    endtask

    task automatic set_obs(input int k, input logic v, input int x, input int y, input int w,
                           input int h, input int sz, input int kd);
        obs_valid[k] = v;
        obs_x[k]     = 11'(x);
        obs_y[k]     = 10'(y);
        obs_w[k]     = 10'(w);
        obs_h[k]     = 10'(h);
        obs_size[k]  = 2'(sz);
        obs_kind[k]  = 2'(kd);
    endtask

    task automatic clear_slots();
        for (int k = 0; k < 3; k++) set_obs(k, 1'b0, 0, 0, 0, 0, 1, 0);
    endtask

    // Cycle count includes the start cycle and the cycle in which done is seen.
    task automatic run_pass(input int restart_at, output int cycles);
        int n;
        n     = 1;
        start = 1'b1;
        while (!done && n < 200) begin
            step();
            n++;
            start = (n == restart_at);
            clear = 1'b0;
        end
        start  = 1'b0;
        cycles = n;
    endtask

    initial begin
        int n;
        int dones;
        rst   = 1'b0;
        start = 1'b0;
        clear = 1'b0;
        set_trex(50, 93, 44, 47, 1'b0);
        clear_slots();
        repeat (2) step();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_hit", hit, 0);
        check("rst_index", hit_index, 0);
        rst = 1'b1;
        step();

        run_pass(0, n);
        check("empty_cycles", n, 5);
        check("empty_hit", hit, 0);
        check("empty_busy_at_done", busy, 0);
        step();
        check("empty_done_one_cycle", done, 0);

        set_obs(1, 1'b1, 60, 105, 17, 35, 1, 0);
        set_obs(2, 1'b1, 600, 90, 25, 50, 1, 1);
        run_pass(0, n);
        check("cactus_cycles", n, 8);
        check("cactus_hit", hit, 1);
        check("cactus_index", hit_index, 1);
        step();

        clear_slots();
        run_pass(0, n);
        check("sticky_cycles", n, 5);
        check("sticky_hit", hit, 1);
        check("sticky_index", hit_index, 1);
        step();

        clear = 1'b1;
        step();
        clear = 1'b0;
        check("clear_hit", hit, 0);
        check("clear_index", hit_index, 0);

        set_obs(0, 1'b1, 40, 60, 46, 40, 1, 2);
        run_pass(0, n);
        check("ptero_fine_miss_cycles", n, 35);
        check("ptero_fine_miss_hit", hit, 0);
        step();

        clear_slots();
        set_obs(2, 1'b1, 60, 75, 46, 40, 1, 2);
        set_trex(50, 93, 44, 47, 1'b1);
        run_pass(0, n);
        check("duck_cycles", n, 10);
        check("duck_hit", hit, 0);
        step();
        set_trex(50, 93, 44, 47, 1'b0);
        run_pass(0, n);
        check("stand_cycles", n, 6);
        check("stand_hit", hit, 1);
        check("stand_index", hit_index, 2);
        step();

        set_trex(50, 93, 44, 47, 1'b1);
        clear = 1'b1;
        run_pass(0, n);
        check("clear_start_cycles", n, 10);
        check("clear_start_hit", hit, 0);
        check("clear_start_index", hit_index, 0);
        step();

        clear_slots();
        set_trex(50, 93, 59, 47, 1'b1);
        set_obs(0, 1'b1, 106, 90, 25, 50, 3, 1);
        run_pass(0, n);
        check("edge_touch_cycles", n, 8);
        check("edge_touch_hit", hit, 0);
        step();
        set_obs(0, 1'b1, 105, 90, 25, 50, 3, 1);
        run_pass(0, n);
        check("edge_overlap_cycles", n, 4);
        check("edge_overlap_hit", hit, 1);
        check("edge_overlap_index", hit_index, 0);
        step();

        clear = 1'b1;
        step();
        clear = 1'b0;
        clear_slots();
        set_trex(50, 93, 44, 47, 1'b0);
        set_obs(1, 1'b1, 26, 90, 25, 50, 3, 1);
        run_pass(0, n);
        check("rescale_cycles", n, 6);
        check("rescale_hit", hit, 1);
        check("rescale_index", hit_index, 1);

        start = 1'b1;
        step();
        check("start_in_finish_ignored", busy, 0);
        step();
        start = 1'b0;
        check("start_in_idle_accepted", busy, 1);
        n = 0;
        while (!done && n < 50) begin
            step();
            n++;
        end
        check("reaccept_done", done, 1);
        check("reaccept_index", hit_index, 1);
        step();

        clear_slots();
        set_obs(0, 1'b1, 40, 60, 46, 40, 1, 2);
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (9) step();
        check("midpass_busy", busy, 1);
        rst = 1'b0;
        #1;
        check("async_rst_busy", busy, 0);
        check("async_rst_hit", hit, 0);
        check("async_rst_index", hit_index, 0);
        check("async_rst_done", done, 0);
        step();
        rst   = 1'b1;
        dones = 0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (done) dones++;
        end
        check("no_done_after_reset", dones, 0);

        run_pass(5, n);
        check("restart_ignored_cycles", n, 35);
        check("restart_ignored_hit", hit, 0);
        dones = 0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (done) dones++;
        end
        check("single_done", dones, 0);

        for (int k = 0; k < 3; k++) set_obs(k, 1'b1, 40, 60, 46, 40, 1, 2);
        run_pass(0, n);
        check("worst_case_cycles", n, 95);
        check("worst_case_hit", hit, 0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
